// File: rtl/cmd_fetch.sv
// Instruction-fetch stage: prefetches sequential command words into a small FIFO
// and feeds the core a fetched word or a self-jump filler every cycle.
module cmd_fetch #(
  parameter int AW         = 8,
  parameter int CMD_W      = 16,
  parameter int DEPTH      = 4,
  parameter int JMP_OPCODE = 5,
  parameter int OPC_LSB    = 12,
  parameter int DAT_LSB    = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [AW-1:0]    IP,
  output logic [CMD_W-1:0] CMD_OUT,
  output logic             HIT,
  output logic             MEM_REQ,
  output logic [AW-1:0]    MEM_ADDR,
  input  logic             MEM_GNT,
  input  logic             MEM_RVALID,
  input  logic [CMD_W-1:0] MEM_RDATA,
  output logic [15:0]      REDIR_CNT
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 2;
  localparam logic [OW-1:0] DEPTH_O = OW'(DEPTH);

  logic [CMD_W-1:0] fifo_mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    cnt, outs, drop;
  logic [AW-1:0]    base, fptr;

  logic             redirect, pop, push, req_gnt;
  logic [OW-1:0]    occupancy, drop_sum;
  logic [CW-1:0]    drop_redir;
  logic [CMD_W-1:0] self_jump;

  // Any IP that is not the stream head is a discontinuity; everything in flight
  // becomes stale and is counted into drop so responses can be discarded in order.
  always_comb begin
    redirect  = (IP != base);
    occupancy = OW'(cnt) + OW'(outs) + OW'(drop);
    MEM_REQ   = RESET && (occupancy < DEPTH_O) && !redirect;
    MEM_ADDR  = fptr;
    req_gnt   = MEM_REQ && MEM_GNT;
    pop       = !redirect && (cnt != '0);
    push      = MEM_RVALID && (drop == '0) && (outs != '0) && !redirect;
    HIT       = pop;
    self_jump = CMD_W'((32'(JMP_OPCODE) << OPC_LSB) | (32'(IP) << DAT_LSB));
    CMD_OUT   = pop ? fifo_mem[rd_ptr] : self_jump;
    drop_sum  = OW'(drop) + OW'(outs) + OW'(req_gnt);
    if (MEM_RVALID && (drop_sum != '0))
      drop_sum = drop_sum - OW'(1);
    drop_redir = CW'(drop_sum);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt       <= '0;
      outs      <= '0;
      drop      <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      base      <= '0;
      fptr      <= '0;
      REDIR_CNT <= '0;
    end else if (redirect) begin
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      base   <= IP;
      fptr   <= IP;
      outs   <= '0;
      drop   <= drop_redir;
      if (REDIR_CNT != 16'hFFFF)
        REDIR_CNT <= REDIR_CNT + 16'd1;
    end else begin
      if (req_gnt)
        fptr <= fptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        base   <= base + AW'(1);
      end
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      cnt  <= cnt + CW'(push) - CW'(pop);
      outs <= outs + CW'(req_gnt) - CW'(push);
      // A response that finds outs and drop both zero is a protocol error and is ignored.
      if (MEM_RVALID && (drop != '0))
        drop <= drop - CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push)
      fifo_mem[wr_ptr] <= MEM_RDATA;
  end

endmodule

// File: tb/tb_cmd_fetch.sv
// Bench for cmd_fetch: directed vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based model of the fetch stream.
module tb_cmd_fetch;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [7:0]  IP = '0;
  logic [15:0] CMD_OUT;
  logic        HIT;
  logic        MEM_REQ;
  logic [7:0]  MEM_ADDR;
  logic        GNT = 1'b0;
  logic        RVALID = 1'b0;
  logic [15:0] RDATA = '0;
  logic [15:0] REDIR_CNT;

  always #5 CLK = ~CLK;

  cmd_fetch #(.AW(8), .CMD_W(16), .DEPTH(DEPTH), .JMP_OPCODE(5), .OPC_LSB(12), .DAT_LSB(0)) dut (
    .CLK(CLK), .RESET(RESET), .IP(IP), .CMD_OUT(CMD_OUT), .HIT(HIT),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_GNT(GNT), .MEM_RVALID(RVALID),
    .MEM_RDATA(RDATA), .REDIR_CNT(REDIR_CNT)
  );

  typedef struct {
    logic [7:0]  ip;
    logic        gnt;
    logic        rv;
    logic [15:0] rdata;
    logic        hit;
    logic [15:0] cmd;
    logic        req;
    logic [7:0]  addr;
    logic [15:0] redir;
  } vec_t;

  typedef struct { logic [7:0] addr; int due; } mreq_t;
  typedef struct { logic [7:0] addr; bit stale; } infl_t;

  vec_t       vecs [18];
  mreq_t      mem_q [$];
  infl_t      m_infl [$];
  logic [7:0] m_fifo [$];
  logic [7:0] m_base, m_next, cur_ip, force_from, force_to;
  logic [7:0] salt = 8'h0;
  bit         force_en;
  bit         seen_hit [256];
  int         m_redir, lat, gnt_pct, jump_pct, cyc;
  int         checks = 0;
  int         failures = 0;

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return {4'h1, salt[3:0], a};
  endfunction

  function automatic logic [15:0] sj(input logic [7:0] a);
    return 16'h5000 | {8'h00, a};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, actual, expected);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b0; GNT = 1'b1; RVALID = 1'b0; RDATA = '0; IP = 8'h37;
    #1;
    checkOutput("rst_req", MEM_REQ, 0);
    checkOutput("rst_hit", HIT, 0);
    checkOutput("rst_cmd", CMD_OUT, 16'h5037);
    checkOutput("rst_redir", REDIR_CNT, 0);
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("rst_req_hold", MEM_REQ, 0);
    mem_q.delete(); m_infl.delete(); m_fifo.delete();
    m_base = '0; m_next = '0; m_redir = 0; cur_ip = '0; cyc = 0;
    salt = salt + 8'd1; force_en = 1'b0;
    foreach (seen_hit[i]) seen_hit[i] = 1'b0;
    IP = '0;
    RESET = 1'b1;
  endtask

  // Memory model: in-order responses, each L cycles after its grant cycle.
  task automatic applyStimulus();
    int due;
    mreq_t r;
    IP = cur_ip;
    GNT = ($urandom_range(99) < gnt_pct);
    RVALID = 1'b0;
    RDATA = 16'($urandom);
    #1;
    if (MEM_REQ && GNT) begin
      due = cyc + lat;
      if (mem_q.size() > 0 && due < mem_q[$].due) due = mem_q[$].due;
      mem_q.push_back('{MEM_ADDR, due});
    end
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      r = mem_q.pop_front();
      RVALID = 1'b1;
      RDATA = mem_word(r.addr);
    end
    #1;
  endtask

  task automatic model_cycle();
    bit redirect, exp_hit, exp_req;
    infl_t r;
    redirect = (cur_ip != m_base);
    exp_hit  = !redirect && m_fifo.size() > 0 && m_fifo[0] == cur_ip;
    exp_req  = !redirect && (m_fifo.size() + m_infl.size() < DEPTH);
    checkOutput("hit", HIT, exp_hit);
    checkOutput("cmd", CMD_OUT, exp_hit ? mem_word(cur_ip) : sj(cur_ip));
    checkOutput("req", MEM_REQ, exp_req);
    checkOutput("addr", MEM_ADDR, m_next);
    checkOutput("redir", REDIR_CNT, m_redir);
    if (exp_hit) begin
      void'(m_fifo.pop_front());
      m_base++;
      seen_hit[cur_ip] = 1'b1;
    end
    if (RVALID && m_infl.size() > 0) begin
      r = m_infl.pop_front();
      if (!r.stale && !redirect) m_fifo.push_back(r.addr);
    end
    if (exp_req && GNT) begin
      m_infl.push_back('{m_next, 1'b0});
      m_next++;
    end
    if (redirect) begin
      foreach (m_infl[i]) m_infl[i].stale = 1'b1;
      m_fifo.delete();
      m_base = cur_ip;
      m_next = cur_ip;
      if (m_redir < 65535) m_redir++;
    end
    // Core model: advances on fetched words, holds on self-jumps, sometimes jumps.
    if (force_en && exp_hit && cur_ip == force_from) begin
      cur_ip = force_to;
      force_en = 1'b0;
    end else if (exp_hit && jump_pct > 0 && $urandom_range(99) < jump_pct)
      cur_ip = 8'($urandom_range(255));
    else if (exp_hit)
      cur_ip++;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      applyStimulus();
      model_cycle();
      @(posedge CLK);
      #1;
      cyc++;
    end
  endtask

  initial begin
    vecs[0]  = '{8'h00, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h5000, 1'b1, 8'h00, 16'd0};
    vecs[1]  = '{8'h00, 1'b1, 1'b1, 16'h1000, 1'b0, 16'h5000, 1'b1, 8'h01, 16'd0};
    vecs[2]  = '{8'h00, 1'b1, 1'b1, 16'h1001, 1'b1, 16'h1000, 1'b1, 8'h02, 16'd0};
    vecs[3]  = '{8'h01, 1'b1, 1'b1, 16'h1002, 1'b1, 16'h1001, 1'b1, 8'h03, 16'd0};
    vecs[4]  = '{8'h02, 1'b1, 1'b1, 16'h1003, 1'b1, 16'h1002, 1'b1, 8'h04, 16'd0};
    vecs[5]  = '{8'h20, 1'b1, 1'b1, 16'h1004, 1'b0, 16'h5020, 1'b0, 8'h05, 16'd0};
    vecs[6]  = '{8'h20, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h5020, 1'b1, 8'h20, 16'd1};
    vecs[7]  = '{8'h20, 1'b1, 1'b1, 16'h1020, 1'b0, 16'h5020, 1'b1, 8'h21, 16'd1};
    vecs[8]  = '{8'h20, 1'b0, 1'b1, 16'h1021, 1'b1, 16'h1020, 1'b1, 8'h22, 16'd1};
    vecs[9]  = '{8'h21, 1'b0, 1'b1, 16'hDEAD, 1'b1, 16'h1021, 1'b1, 8'h22, 16'd1};
    vecs[10] = '{8'h22, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h5022, 1'b1, 8'h22, 16'd1};
    vecs[11] = '{8'h40, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h5040, 1'b0, 8'h22, 16'd1};
    vecs[12] = '{8'h40, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h5040, 1'b1, 8'h40, 16'd2};
    vecs[13] = '{8'h40, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h5040, 1'b1, 8'h41, 16'd2};
    vecs[14] = '{8'h10, 1'b1, 1'b1, 16'h1040, 1'b0, 16'h5010, 1'b0, 8'h42, 16'd2};
    vecs[15] = '{8'h10, 1'b1, 1'b1, 16'h1041, 1'b0, 16'h5010, 1'b1, 8'h10, 16'd3};
    vecs[16] = '{8'h10, 1'b1, 1'b1, 16'h1010, 1'b0, 16'h5010, 1'b1, 8'h11, 16'd3};
    vecs[17] = '{8'h10, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1010, 1'b1, 8'h12, 16'd3};

    do_reset();
    for (int i = 0; i < 18; i++) begin
      IP = vecs[i].ip; GNT = vecs[i].gnt; RVALID = vecs[i].rv; RDATA = vecs[i].rdata;
      #2;
      checkOutput($sformatf("vec%0d_hit", i), HIT, vecs[i].hit);
      checkOutput($sformatf("vec%0d_cmd", i), CMD_OUT, vecs[i].cmd);
      checkOutput($sformatf("vec%0d_req", i), MEM_REQ, vecs[i].req);
      checkOutput($sformatf("vec%0d_addr", i), MEM_ADDR, vecs[i].addr);
      checkOutput($sformatf("vec%0d_redir", i), REDIR_CNT, vecs[i].redir);
      @(posedge CLK);
      #1;
      cyc++;
    end

    // Latency 3 stream, core jumps from 5 to 0x20 while responses are in flight.
    do_reset();
    lat = 3; gnt_pct = 100; jump_pct = 0;
    force_en = 1'b1; force_from = 8'h05; force_to = 8'h20;
    run(30);
    checkOutput("jmp_redir", REDIR_CNT, 1);
    checkOutput("jmp_hit20", seen_hit[8'h20], 1);
    checkOutput("jmp_nohit6", seen_hit[8'h06], 0);

    // Address wrap from 0xFE is sequential.
    do_reset();
    lat = 1; cur_ip = 8'hFE;
    run(12);
    checkOutput("wrap_redir", REDIR_CNT, 1);
    checkOutput("wrap_fe", seen_hit[8'hFE], 1);
    checkOutput("wrap_ff", seen_hit[8'hFF], 1);
    checkOutput("wrap_00", seen_hit[8'h00], 1);

    // Reset with two requests outstanding, then restart on a fresh memory.
    do_reset();
    lat = 3;
    run(2);
    do_reset();
    run(16);
    checkOutput("rst_restart_hit0", seen_hit[8'h00], 1);

    for (int p = 0; p < 6; p++) begin
      do_reset();
      lat = p + 1;
      gnt_pct = (p % 2 == 0) ? 100 : 40 + 10 * p;
      jump_pct = 8;
      run(400);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
